// File: rtl/instru_loader_if.sv
// Byte-stream handshake carrying the boot image into the instruction loader.
//   byte_valid : source has a byte on byte_data this cycle
//   byte_data  : byte payload, big-endian within each 32-bit word
//   byte_ready : loader consumes the byte on this cycle if byte_valid is also high
// Modports:
//   master : byte source (host / UART bridge / testbench)
//   slave  : the loader
interface instru_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );
endinterface

// File: rtl/instru_loader.sv
// Boot-time loader for the single-cycle core's instruction memory.
// Collects a big-endian byte stream into 32-bit words and writes them to consecutive word
// slots starting at address 0, keeping the CPU stalled until the requested number of words
// has been written. Once loading completes, the CPU's PC is passed through as the fetch
// address.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle load request, honoured in IDLE, RUN and ERR
//   word_count : number of words to load, sampled together with start
//   bs         : byte-stream slave (byte_valid, byte_data, byte_ready)
//   pc         : CPU fetch byte address, forwarded to mem_addr in RUN
//   mem_addr   : instruction memory byte address (memory uses addr>>2)
//   mem_we     : one-cycle word write strobe
//   mem_wdata  : assembled word, held between writes
//   cpu_stall  : freezes the CPU whenever the loader is not in RUN
//   done       : high while in RUN
//   error      : high while in ERR (requested length exceeded memory depth)
module instru_loader #(
  parameter int unsigned SIZE_IM = 128,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     word_count,
  instru_loader_if.slave       bs,
  input  logic [31:0]          pc,
  output logic [31:0]          mem_addr,
  output logic                 mem_we,
  output logic [31:0]          mem_wdata,
  output logic                 cpu_stall,
  output logic                 done,
  output logic                 error
);

  localparam logic [CNT_W-1:0] SizeImW = CNT_W'(SIZE_IM);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrite,
    StRun,
    StErr
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         lane_q, lane_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [31:0]        asm_q, asm_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_inc;

  // Word slot address; also the write address during WRITE.
  logic [31:0]        slot_addr;

  assign cnt_inc   = cnt_q + 1'b1;
  assign slot_addr = {{(30 - CNT_W){1'b0}}, cnt_q, 2'b00};

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      lane_q   <= '0;
      cnt_q    <= '0;
      target_q <= '0;
      asm_q    <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      asm_q    <= asm_d;
      wdata_q  <= wdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    asm_d    = asm_q;
    wdata_d  = wdata_q;

    unique case (state_q)
      StIdle, StRun, StErr: begin
        if (start) begin
          if (word_count == '0) begin
            // Empty image: nothing to write, release the CPU right away.
            state_d = StRun;
          end else if (word_count > SizeImW) begin
            state_d = StErr;
          end else begin
            target_d = word_count;
            cnt_d    = '0;
            lane_d   = '0;
            state_d  = StLoad;
          end
        end
      end

      StLoad: begin
        // byte_ready is high throughout LOAD, so byte_valid alone means acceptance.
        if (bs.byte_valid) begin
          unique case (lane_q)
            2'd0: asm_d[31:24] = bs.byte_data;
            2'd1: asm_d[23:16] = bs.byte_data;
            2'd2: asm_d[15:8]  = bs.byte_data;
            2'd3: begin
              asm_d[7:0] = bs.byte_data;
              // Last lane bypasses the assembly register so the word is ready for WRITE.
              wdata_d    = {asm_q[31:8], bs.byte_data};
              state_d    = StWrite;
            end
            default: ;
          endcase
          lane_d = lane_q + 2'd1;
        end
      end

      StWrite: begin
        cnt_d = cnt_inc;
        if (cnt_inc == target_q) begin
          state_d = StRun;
        end else begin
          state_d = StLoad;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    bs.byte_ready = 1'b0;
    mem_we        = 1'b0;
    cpu_stall     = 1'b1;
    done          = 1'b0;
    error         = 1'b0;
    mem_addr      = slot_addr;

    unique case (state_q)
      StLoad:  bs.byte_ready = 1'b1;
      StWrite: mem_we = 1'b1;
      StRun: begin
        cpu_stall = 1'b0;
        done      = 1'b1;
        mem_addr  = pc;
      end
      StErr:   error = 1'b1;
      default: ;
    endcase
  end

  assign mem_wdata = wdata_q;

endmodule
